spi_reg_burst_slave: RTL and testbench

Parametrised SPI mode-0 slave that bridges an external SPI master onto the on-chip register bus. It supports configurable address and data widths, multi-word burst reads and writes with optional address auto-increment, a fixed one-bit read turnaround, and reports frames that end on a partial word. It sits between the chip SPI pads (SCLK/MOSI/CSN/MISO) and the register file, and succeeds the fixed 10-bit/8-bit single-word interface.

---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/spi_miso_stage.sv | 24 ++
 rtl/spi_reg_burst_slave.sv | 156 +++++++++++++++
 tb/tb_spi_reg_burst_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared states, frame constants and sizing helper for the SPI register slave
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_TURN,
        ST_RDATA,
        ST_WDATA
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam int   TURN_LEN = 1;

    function automatic int cnt_width(input int addr_w, input int data_w);
        int widest;
        widest = (addr_w > data_w) ? addr_w : data_w;
        return $clog2(widest + 1);
    endfunction

endpackage

// File: rtl/spi_miso_stage.sv
// rtl/spi_miso_stage.sv - falling-edge MISO launch and pad output-enable registers
module spi_miso_stage
    import spi_reg_pkg::*;
(
    input  logic   sclk,
    input  logic   rst,
    input  state_t state,
    input  logic   data_msb,
    output logic   miso,
    output logic   miso_enable
);

    // The pad is enabled through the turnaround so the master sees a driven line before the MSB.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            miso        <= 1'b0;
            miso_enable <= 1'b0;
        end else begin
            miso_enable <= (state == ST_TURN) || (state == ST_RDATA);
            miso        <= (state == ST_RDATA) && data_msb;
        end
    end

endmodule

// File: rtl/spi_reg_burst_slave.sv
// rtl/spi_reg_burst_slave.sv - SPI mode-0 slave bridging burst reads/writes onto the register bus
module spi_reg_burst_slave
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              SCLK,
    input  logic              rst,
    input  logic              MOSI,
    input  logic              CSN,
    input  logic [DATA_W-1:0] reg_read_data,
    output logic              MISO,
    output logic              MISO_enable,
    output logic [ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              reg_write_enable,
    output logic              reg_read_enable,
    output logic              frame_error
);

    localparam int CW = cnt_width(ADDR_W, DATA_W);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_LEN - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] WORD_PREF = CW'(DATA_W - 2);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     bit_cnt;
    logic              rw;
    logic [ADDR_W-2:0] addr_sr;
    logic [DATA_W-2:0] wr_sr;
    logic [DATA_W-1:0] rd_buf;
    logic              wr_committed;
    logic [ADDR_W-1:0] addr_shift;
    logic [DATA_W-1:0] wr_word;
    logic              addr_done;
    logic              turn_done;
    logic              word_done;

    assign addr_shift = {addr_sr, MOSI};
    assign wr_word    = {wr_sr, MOSI};
    assign addr_done  = (state == ST_ADDR) && (bit_cnt == ADDR_LAST);
    assign turn_done  = (state == ST_TURN) && (bit_cnt == TURN_LAST);
    assign word_done  = ((state == ST_RDATA) || (state == ST_WDATA)) && (bit_cnt == WORD_LAST);

    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (CSN) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_ADDR;
                ST_ADDR: if (addr_done) state_next = (rw == RW_READ) ? ST_TURN : ST_WDATA;
                ST_TURN: if (turn_done) state_next = ST_RDATA;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            bit_cnt          <= '0;
            rw               <= 1'b0;
            addr_sr          <= '0;
            wr_sr            <= '0;
            rd_buf           <= '0;
            wr_committed     <= 1'b0;
            reg_address      <= '0;
            reg_write_data   <= '0;
            reg_write_enable <= 1'b0;
            reg_read_enable  <= 1'b0;
            frame_error      <= 1'b0;
        end else begin
            reg_write_enable <= 1'b0;
            reg_read_enable  <= 1'b0;
            frame_error      <= 1'b0;
            if (CSN) begin
                // Deselect wins over any word completing on the same edge.
                bit_cnt     <= '0;
                frame_error <= (state == ST_ADDR) || (state == ST_TURN) ||
                               (((state == ST_RDATA) || (state == ST_WDATA)) && (bit_cnt != '0));
            end else begin
                case (state)
                    ST_IDLE: begin
                        rw           <= MOSI;
                        bit_cnt      <= '0;
                        wr_committed <= 1'b0;
                    end
                    ST_ADDR: begin
                        addr_sr <= addr_shift[ADDR_W-2:0];
                        if (addr_done) begin
                            reg_address     <= addr_shift;
                            reg_read_enable <= (rw == RW_READ);
                            bit_cnt         <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    ST_TURN: begin
                        if (turn_done) begin
                            rd_buf  <= reg_read_data;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    ST_RDATA: begin
                        if (word_done) begin
                            rd_buf  <= reg_read_data;
                            bit_cnt <= '0;
                        end else begin
                            rd_buf  <= {rd_buf[DATA_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                        // Fetch one bit early so the next word is ready on the last-bit edge.
                        if (bit_cnt == WORD_PREF) begin
                            reg_read_enable <= 1'b1;
                            if (AUTO_INC) reg_address <= reg_address + ADDR_W'(1);
                        end
                    end
                    ST_WDATA: begin
                        wr_sr <= wr_word[DATA_W-2:0];
                        if (word_done) begin
                            reg_write_data   <= wr_word;
                            reg_write_enable <= 1'b1;
                            wr_committed     <= 1'b1;
                            bit_cnt          <= '0;
                            if (AUTO_INC && wr_committed) reg_address <= reg_address + ADDR_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    default: bit_cnt <= '0;
                endcase
            end
        end
    end

    spi_miso_stage u_miso_stage (
        .sclk        (SCLK),
        .rst         (rst),
        .state       (state),
        .data_msb    (rd_buf[DATA_W-1]),
        .miso        (MISO),
        .miso_enable (MISO_enable)
    );

endmodule

// File: tb/tb_spi_reg_burst_slave.sv
// tb/tb_spi_reg_burst_slave.sv - scoreboard bench for the SPI register burst slave
`timescale 1ns/1ps
module tb_spi_reg_burst_slave;
    import spi_reg_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            edge_no;
    } xact_t;

    logic          SCLK = 1'b0;
    logic          rst = 1'b0;
    logic          MOSI = 1'b0;
    logic          csn_main = 1'b1;
    logic          csn_alt = 1'b1;
    logic [DW-1:0] reg_read_data = '0;

    logic          MISO, MISO_enable, reg_write_enable, reg_read_enable, frame_error;
    logic [AW-1:0] reg_address;
    logic [DW-1:0] reg_write_data;
    logic          alt_miso, alt_miso_enable, alt_we, alt_re, alt_ferr;
    logic [AW-1:0] alt_addr;
    logic [DW-1:0] alt_wdata;

    xact_t exp_wr[$];
    xact_t exp_wr_alt[$];
    xact_t exp_rd[$];
    logic  exp_miso[$];
    int    exp_ferr = 0;
    logic  miso_window = 1'b0;
    logic  men_off_chk = 1'b0;
    int    cur_edge = -1;
    int    checks = 0;
    int    passes = 0;
    xact_t mon_t;
    logic  mon_b;

    always #5 SCLK = ~SCLK;

    spi_reg_burst_slave #(.ADDR_W(AW), .DATA_W(DW), .AUTO_INC(1'b1)) u_dut (
        .SCLK(SCLK), .rst(rst), .MOSI(MOSI), .CSN(csn_main), .reg_read_data(reg_read_data),
        .MISO(MISO), .MISO_enable(MISO_enable), .reg_address(reg_address),
        .reg_write_data(reg_write_data), .reg_write_enable(reg_write_enable),
        .reg_read_enable(reg_read_enable), .frame_error(frame_error)
    );

    spi_reg_burst_slave #(.ADDR_W(AW), .DATA_W(DW), .AUTO_INC(1'b0)) u_alt (
        .SCLK(SCLK), .rst(rst), .MOSI(MOSI), .CSN(csn_alt), .reg_read_data(reg_read_data),
        .MISO(alt_miso), .MISO_enable(alt_miso_enable), .reg_address(alt_addr),
        .reg_write_data(alt_wdata), .reg_write_enable(alt_we),
        .reg_read_enable(alt_re), .frame_error(alt_ferr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    always @(posedge SCLK) begin
        if (csn_main && csn_alt) cur_edge = -1;
        else                     cur_edge = cur_edge + 1;
        if (miso_window) begin
            check("miso_bit_expected", exp_miso.size() > 0, 1);
            if (exp_miso.size() > 0) begin
                mon_b = exp_miso.pop_front();
                check("miso_bit", MISO, mon_b);
                check("miso_enable_on", MISO_enable, 1);
            end
        end
    end

    always @(negedge SCLK) begin
        if (reg_write_enable) begin
            check("write_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                mon_t = exp_wr.pop_front();
                check("wr_addr", reg_address, mon_t.addr);
                check("wr_data", reg_write_data, mon_t.data);
                check("wr_edge", cur_edge, mon_t.edge_no);
            end
        end
        if (reg_read_enable) begin
            check("read_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
                mon_t = exp_rd.pop_front();
                check("rd_addr", reg_address, mon_t.addr);
                check("rd_edge", cur_edge, mon_t.edge_no);
                reg_read_data = mon_t.data;
            end
        end
        if (alt_we) begin
            check("alt_write_expected", exp_wr_alt.size() > 0, 1);
            if (exp_wr_alt.size() > 0) begin
                mon_t = exp_wr_alt.pop_front();
                check("alt_wr_addr", alt_addr, mon_t.addr);
                check("alt_wr_data", alt_wdata, mon_t.data);
                check("alt_wr_edge", cur_edge, mon_t.edge_no);
            end
        end
        if (frame_error) begin
            check("frame_error_expected", exp_ferr > 0, 1);
            if (exp_ferr > 0) exp_ferr--;
        end
        if (men_off_chk) check("miso_enable_off", MISO_enable, 0);
    end

    task automatic send_bit(input logic b, input logic to_alt, input logic win);
        @(negedge SCLK);
        MOSI        = b;
        csn_main    = to_alt;
        csn_alt     = ~to_alt;
        miso_window = win;
    endtask

    task automatic end_frame();
        @(negedge SCLK);
        csn_main    = 1'b1;
        csn_alt     = 1'b1;
        miso_window = 1'b0;
        MOSI        = 1'b0;
        repeat (2) @(negedge SCLK);
    endtask

    task automatic send_header(input logic rw, input logic [AW-1:0] addr, input logic to_alt);
        send_bit(rw, to_alt, 1'b0);
        for (int i = AW - 1; i >= 0; i--) send_bit(addr[i], to_alt, 1'b0);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int nbits, input logic to_alt);
        for (int i = DW - 1; i >= DW - nbits; i--) send_bit(w[i], to_alt, 1'b0);
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [3*DW-1:0] words,
                               input int n, input logic to_alt);
        send_header(RW_WRITE, addr, to_alt);
        for (int k = 0; k < n; k++) send_word(words[k*DW +: DW], DW, to_alt);
        end_frame();
    endtask

    task automatic read_start(input logic [AW-1:0] addr);
        send_header(RW_READ, addr, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int n);
        read_start(addr);
        for (int i = 0; i < n * DW; i++) send_bit(1'b0, 1'b0, 1'b1);
        end_frame();
    endtask

    task automatic push_bits(input logic [DW-1:0] v);
        for (int i = DW - 1; i >= 0; i--) exp_miso.push_back(v[i]);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("reset_miso", {MISO, MISO_enable}, 0);
        check("reset_addr", reg_address, 0);
        check("reset_wdata", reg_write_data, 0);
        check("reset_strobes", {reg_write_enable, reg_read_enable, frame_error}, 0);
        repeat (2) @(negedge SCLK);
        rst = 1'b0;
        repeat (2) @(negedge SCLK);

        men_off_chk = 1'b1;
        exp_wr.push_back('{10'h155, 8'hA5, 18});
        write_burst(10'h155, {16'h0, 8'hA5}, 1, 1'b0);
        men_off_chk = 1'b0;

        exp_rd.push_back('{10'h0F3, 8'h3C, 10});
        exp_rd.push_back('{10'h0F4, 8'h00, 18});
        push_bits(8'h3C);
        read_burst(10'h0F3, 1);

        exp_wr.push_back('{10'h3FF, 8'h11, 18});
        exp_wr.push_back('{10'h000, 8'h22, 26});
        exp_wr.push_back('{10'h001, 8'h33, 34});
        write_burst(10'h3FF, {8'h33, 8'h22, 8'h11}, 3, 1'b0);

        exp_wr_alt.push_back('{10'h3FF, 8'h11, 18});
        exp_wr_alt.push_back('{10'h3FF, 8'h22, 26});
        exp_wr_alt.push_back('{10'h3FF, 8'h33, 34});
        write_burst(10'h3FF, {8'h33, 8'h22, 8'h11}, 3, 1'b1);

        exp_rd.push_back('{10'h010, 8'hC3, 10});
        exp_rd.push_back('{10'h011, 8'h5A, 18});
        exp_rd.push_back('{10'h012, 8'h00, 26});
        push_bits(8'hC3);
        push_bits(8'h5A);
        read_burst(10'h010, 2);

        exp_ferr++;
        send_header(RW_WRITE, 10'h0AA, 1'b0);
        send_word(8'hA0, 4, 1'b0);
        end_frame();

        exp_ferr++;
        send_header(RW_WRITE, 10'h0AA, 1'b0);
        send_word(8'hFE, 7, 1'b0);
        end_frame();

        exp_wr.push_back('{10'h0AA, 8'h5C, 18});
        write_burst(10'h0AA, {16'h0, 8'h5C}, 1, 1'b0);

        exp_rd.push_back('{10'h2A5, 8'h96, 10});
        exp_miso.push_back(1'b1);
        exp_miso.push_back(1'b0);
        read_start(10'h2A5);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        @(posedge SCLK);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_miso", {MISO, MISO_enable}, 0);
        check("rst_mid_addr", reg_address, 0);
        check("rst_mid_strobes", {reg_write_enable, reg_read_enable, frame_error}, 0);
        @(negedge SCLK);
        rst      = 1'b0;
        csn_main = 1'b1;
        repeat (2) @(negedge SCLK);

        exp_rd.push_back('{10'h07E, 8'h81, 10});
        exp_rd.push_back('{10'h07F, 8'h00, 18});
        push_bits(8'h81);
        read_burst(10'h07E, 1);

        repeat (4) @(negedge SCLK);
        check("writes_left", exp_wr.size(), 0);
        check("alt_writes_left", exp_wr_alt.size(), 0);
        check("reads_left", exp_rd.size(), 0);
        check("miso_bits_left", exp_miso.size(), 0);
        check("frame_errors_left", exp_ferr, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
